// File: rtl/dec_scan_ctrl_if.sv
// Handshake/control bundle between a scan-sequencer client and dec_scan_ctrl.
// The sequencer side uses the slave modport; the client (or bench) uses master.
interface dec_scan_ctrl_if;
   logic       start;
   logic       stop;
   logic [7:0] mask;
   logic [2:0] Din;
   logic       en;
   logic       busy;
   logic       wrap;

   modport master (
      output start, stop, mask,
      input  Din, en, busy, wrap
   );

   modport slave (
      input  start, stop, mask,
      output Din, en, busy, wrap
   );
endinterface

// File: rtl/dec_scan_ctrl.sv
// Scan sequencer for a dec3to8 decoder: sweeps Din 0..7 with DIV dwell cycles
// and BLANK blanking cycles per position. Define SCAN_SKIP_EN to honour mask.
module dec_scan_ctrl #(
   parameter int DIV   = 4,
   parameter int BLANK = 1
) (
   input  logic           clk,
   input  logic           rst,
   dec_scan_ctrl_if.slave bus
);

   localparam int MAX_DB    = (DIV > BLANK) ? DIV : BLANK;
   localparam int CNT_RANGE = (MAX_DB > 2) ? MAX_DB : 2;
   localparam int CW        = $clog2(CNT_RANGE);
   localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [2:0]    r_sel;
   logic [2:0]    w_sel_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_wrap;
   logic          w_wrap_nxt;
   logic          r_en;
   logic          r_busy;
   logic          w_adv;

`ifdef SCAN_SKIP_EN
   // r_hunt: GAP is waiting for a mask bit rather than counting blanking.
   // r_first: the pending advance is the first position of a fresh scan.
   logic       r_hunt;
   logic       w_hunt_nxt;
   logic       r_first;
   logic       w_first_nxt;
   logic [3:0] w_pick;

   // Nearest set mask bit cyclically after base (base itself last); {found, index}.
   function automatic logic [3:0] next_pos(input logic [2:0] base, input logic [7:0] m);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'd0;
      for (int i = 8; i >= 1; i--) begin
         idx = base + 3'(i);
         if (m[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction
`endif

   // Next-state, next-position and wrap-pulse decode.
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = r_cnt;
      w_wrap_nxt  = 1'b0;
      w_adv       = 1'b0;
`ifdef SCAN_SKIP_EN
      w_hunt_nxt  = r_hunt;
      w_first_nxt = r_first;
      w_pick      = 4'd0;
`endif
      case (r_state)
         ST_IDLE: begin
            w_sel_nxt = 3'd0;
            w_cnt_nxt = '0;
            if (bus.start && !bus.stop) begin
`ifdef SCAN_SKIP_EN
               w_first_nxt = 1'b1;
               w_adv       = 1'b1;
`else
               w_state_nxt = ST_SHOW;
               w_wrap_nxt  = 1'b1;
`endif
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SHOW: begin
            if (r_cnt == DIV_LAST) begin
               w_cnt_nxt = '0;
               if (BLANK > 0) begin
                  w_state_nxt = ST_GAP;
               end else begin
                  w_adv = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_GAP: begin
`ifdef SCAN_SKIP_EN
            if (r_hunt || (r_cnt == BLANK_LAST)) begin
`else
            if (r_cnt == BLANK_LAST) begin
`endif
               w_adv = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_sel_nxt   = 3'd0;
            w_cnt_nxt   = '0;
         end
      endcase

      // A fresh scan searches from index 7 so the lowest set bit is found first.
      if (w_adv) begin
         w_cnt_nxt = '0;
`ifdef SCAN_SKIP_EN
         w_pick = next_pos(w_first_nxt ? 3'd7 : r_sel, bus.mask);
         if (w_pick[3]) begin
            w_state_nxt = ST_SHOW;
            w_sel_nxt   = w_pick[2:0];
            w_wrap_nxt  = w_first_nxt || (w_pick[2:0] <= r_sel);
            w_hunt_nxt  = 1'b0;
            w_first_nxt = 1'b0;
         end else begin
            w_state_nxt = ST_GAP;
            w_hunt_nxt  = 1'b1;
         end
`else
         w_state_nxt = ST_SHOW;
         w_sel_nxt   = r_sel + 3'd1;
         w_wrap_nxt  = (r_sel == 3'd7);
`endif
      end else begin
         w_wrap_nxt = w_wrap_nxt;
      end

      if (bus.stop) begin
         w_state_nxt = ST_IDLE;
         w_sel_nxt   = 3'd0;
         w_cnt_nxt   = '0;
         w_wrap_nxt  = 1'b0;
`ifdef SCAN_SKIP_EN
         w_hunt_nxt  = 1'b0;
         w_first_nxt = 1'b0;
`endif
      end else begin
         w_state_nxt = w_state_nxt;
      end
   end

   // State, position, counter and registered output update.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_sel   <= 3'd0;
         r_cnt   <= '0;
         r_wrap  <= 1'b0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
`ifdef SCAN_SKIP_EN
         r_hunt  <= 1'b0;
         r_first <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wrap  <= w_wrap_nxt;
         r_en    <= (w_state_nxt == ST_SHOW);
         r_busy  <= (w_state_nxt != ST_IDLE);
`ifdef SCAN_SKIP_EN
         r_hunt  <= w_hunt_nxt;
         r_first <= w_first_nxt;
`endif
      end
   end

   assign bus.Din  = r_sel;
   assign bus.en   = r_en;
   assign bus.busy = r_busy;
   assign bus.wrap = r_wrap;

endmodule
